banked_scratchpad: RTL and testbench
====================================

# banked_scratchpad

Parametrised successor to the GEMM byte-banked dual-port scratchpad. It adds a burst/stride engine on the accelerator port, valid/ready request handshaking, and bank-conflict stalling against the system-bus port. The block sits between the GEMM interface controller (port A: wide, unaligned, multi-beat) and the RISC-V data bus (port B: `SYS_LANES` bytes, single-cycle, never stalls). Memory contents are not reset.

## Interface
- `NUM_BANKS`, 16: byte banks; power of 2, ≥ `SYS_LANES`. `OFS_W` = log2(`NUM_BANKS`).
- `BANK_DEPTH`, 16: rows per bank; power of 2. `ROW_W` = log2(`BANK_DEPTH`).
- `D_WID`, 8: bits per bank entry.
- `SYS_LANES`, 4: port B byte lanes.
- `BEAT_W`, 8: width of the beat-count field.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `a_req_valid` in 1: burst request valid.
- `a_req_ready` out 1: high only in IDLE.
- `a_req_wr` in 1: 1 = write burst, 0 = read burst.
- `a_req_addr` in 32: byte address of beat 0.
- `a_req_len` in `OFS_W`+1: bytes per beat, 0..`NUM_BANKS`; 0 gives an all-zero mask.
- `a_req_beats` in `BEAT_W`: number of beats minus 1.
- `a_req_stride` in 32: byte increment between beats (wraps mod 2^32).
- `a_wr_data` in `NUM_BANKS`×`D_WID`: write bytes, lane k = byte at addr+k; consumed when `a_beat_ack` is high.
- `a_beat_ack` out 1: a beat issued to the banks this cycle.
- `a_rd_valid` / `a_rd_last` out 1 / 1: read beat valid / final beat of burst.
- `a_rd_data` out `NUM_BANKS`×`D_WID`: lane k = byte at beat addr+k; lanes ≥ len read 0.
- `b_en`, `b_wr` in 1, 1: system access enable / write.
- `b_mask` in `SYS_LANES`: byte write enables.
- `b_addr` in 32: byte address, any alignment.
- `b_wr_data` in `SYS_LANES`×`D_WID`: write bytes.
- `b_rd_data` out `SYS_LANES`×`D_WID`: read bytes.
- `b_rd_valid` out 1: read data valid.

## Operation
- **Mapping.** Byte k of access at addr goes to bank (addr[OFS_W-1:0]+k) mod `NUM_BANKS`. Its row is addr[OFS_W+ROW_W-1:OFS_W], plus 1 if the bank index < addr[OFS_W-1:0], taken mod `BANK_DEPTH`. Higher address bits are ignored.
- **FSM IDLE.** `a_req_ready`=1. On valid&&ready, capture wr, addr, len, beats, stride into cur_addr/cnt and go to BURST. No beat issues in the accept cycle.
- **FSM BURST.** Each cycle, a beat issues unless there is a conflict. On issue:
  - `a_beat_ack`=1;
  - cur_addr += stride; cnt -= 1;
  - if cnt was 0, return to IDLE (ready high the next cycle).
- **Conflict.** Exists when `b_en`=1, A and B share at least one bank at the same row, and either access writes (for B: `b_wr`&&mask bit of the shared byte).
  - Port B wins and A holds: no ack, cur_addr and cnt unchanged.
  - Read/read to the same row is not a conflict.
- `a_req_valid` while busy is ignored.
- **Read beats.** Per-beat offset, len and a last flag are pipelined one stage; the output rotation and mask use these registered values.
- **Port B.** Accepted every cycle. `b_rd_valid` follows `b_en`&&!`b_wr` by one cycle.
- **Reset mid-burst.** FSM returns to IDLE, cnt=0, pipeline valids cleared. A partially written burst stays partially written.

## Timing
- Reset values:
  - `a_req_ready`=1; `a_beat_ack`=0; `a_rd_valid`=0; `a_rd_last`=0; `a_rd_data`=0;
  - `b_rd_valid`=0; `b_rd_data`=0.
- **Read latency:** 1 cycle from beat issue (A) or `b_en` (B).
- **Burst duration:** minimum burst of N beats is 1 accept cycle + N issue cycles; each conflict adds 1 cycle.
- **Combinational path:** `a_beat_ack` depends on `b_en`/`b_addr`/`b_mask`/`b_wr` through the conflict check. The driver must not make `b_*` depend on `a_beat_ack`.
- **Same-cycle A write + B read** to different rows of the same bank: both proceed (true dual port).

## Structure
- **Package `gemm_mem_pkg`:**
  - derived widths (`OFS_W`, `ROW_W`);
  - `burst_state_e` {IDLE, BURST};
  - a `bank_map` function returning bank index and row for (addr, k).
- **Sub-module `bank_sram`:** one true-dual-port `D_WID`×`BANK_DEPTH` bank with per-port en/we and a registered read. It is generated `NUM_BANKS` times.
- Rotation, masking, conflict check and FSM live in the top.

## Test plan
- **Aligned write then read:** write burst addr=0x00, len=16, beats=0, bytes 0x00..0x0F; then read the same → one ack. Read returns 0x00..0x0F one cycle after its ack, with `a_rd_last`=1.
- **Unaligned wrap:** B writes 0xAABBCCDD at addr=0x0E mask=0xF → banks 14,15 row 0 and banks 0,1 row 1 written. A read at addr=0x0E, len=4 returns DD,CC,BB,AA and zeros in lanes 4..15.
- **Strided burst:** read addr=0x03, len=5, beats=3, stride=0x20 → acks at addr 0x03, 0x23, 0x43, 0x63 on 4 consecutive cycles; `a_rd_last` only on the 4th data beat.
- **Conflict stall:** A write beat to addr=0x10 with B write `b_addr`=0x12, mask=0x1 in the same cycle → no ack, B data stored. A issues next cycle. Final memory byte at 0x12 is A's data.
- **Read/read no conflict:** A read and B read to the same row in the same cycle → ack=1, both valid the next cycle.
- **Reset mid-burst:** assert `rst` during beat 2 of 8 → outputs take their reset values immediately. `a_req_ready`=1 after release, and a new request is accepted normally.

Source files
------------

// File: rtl/gemm_mem_pkg.sv
// Shared types and address-mapping helper for the byte-banked scratchpad.
// Default geometry lives here; the top re-derives widths from its own parameters.
package gemm_mem_pkg;

    localparam int OFS_W = 4;
    localparam int ROW_W = 4;

    typedef enum logic {
        IDLE,
        BURST
    } burst_state_e;

    typedef struct packed {
        logic [31:0] bank;
        logic [31:0] row;
    } bank_loc_t;

    // Byte k of an access at addr: bank rotates with the offset, row carries
    // into the next line once the lane wraps past the last bank.
    function automatic bank_loc_t bank_map(input logic [31:0] addr, input logic [31:0] k,
                                           input int ofs_w, input int row_w);
        logic [31:0] ofs_mask;
        logic [31:0] row_mask;
        logic [31:0] ofs;
        bank_loc_t   loc;
        ofs_mask = (32'd1 << ofs_w) - 32'd1;
        row_mask = (32'd1 << row_w) - 32'd1;
        ofs      = addr & ofs_mask;
        loc.bank = (ofs + k) & ofs_mask;
        loc.row  = ((addr >> ofs_w) + ((loc.bank < ofs) ? 32'd1 : 32'd0)) & row_mask;
        return loc;
    endfunction

endpackage

// File: rtl/bank_sram.sv
// One true-dual-port byte bank with registered read on each port.
// Writes never collide in practice: the top stalls port A on any shared-row write.
module bank_sram
    import gemm_mem_pkg::*;
#(
    parameter int D_WID = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             a_en,
    input  logic             a_we,
    input  logic [AW-1:0]    a_addr,
    input  logic [D_WID-1:0] a_wdata,
    output logic [D_WID-1:0] a_rdata,
    input  logic             b_en,
    input  logic             b_we,
    input  logic [AW-1:0]    b_addr,
    input  logic [D_WID-1:0] b_wdata,
    output logic [D_WID-1:0] b_rdata
);

    logic [D_WID-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (a_en && a_we) mem[a_addr] <= a_wdata;
        if (b_en && b_we) mem[b_addr] <= b_wdata;
        if (a_en) a_rdata <= mem[a_addr];
        if (b_en) b_rdata <= mem[b_addr];
    end

endmodule

// File: rtl/banked_scratchpad.sv
// Byte-banked dual-port scratchpad: burst/stride engine on port A, single-cycle
// system port B that always wins a bank conflict.
module banked_scratchpad
    import gemm_mem_pkg::*;
#(
    parameter int NUM_BANKS  = 16,
    parameter int BANK_DEPTH = 16,
    parameter int D_WID      = 8,
    parameter int SYS_LANES  = 4,
    parameter int BEAT_W     = 8,
    localparam int BOW       = $clog2(NUM_BANKS),
    localparam int RAW       = $clog2(BANK_DEPTH),
    localparam int AW        = NUM_BANKS * D_WID,
    localparam int BW        = SYS_LANES * D_WID
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_wr,
    input  logic [31:0]       a_req_addr,
    input  logic [BOW:0]      a_req_len,
    input  logic [BEAT_W-1:0] a_req_beats,
    input  logic [31:0]       a_req_stride,
    input  logic [AW-1:0]     a_wr_data,
    output logic              a_beat_ack,
    output logic              a_rd_valid,
    output logic              a_rd_last,
    output logic [AW-1:0]     a_rd_data,
    input  logic              b_en,
    input  logic              b_wr,
    input  logic [SYS_LANES-1:0] b_mask,
    input  logic [31:0]       b_addr,
    input  logic [BW-1:0]     b_wr_data,
    output logic [BW-1:0]     b_rd_data,
    output logic              b_rd_valid
);

    burst_state_e state_q, state_d;
    logic [31:0]       cur_addr, cur_stride;
    logic [BOW:0]      cur_len;
    logic              cur_wr;
    logic [BEAT_W-1:0] cnt;
    logic              rd_valid, rd_last, b_rd_valid_q;
    logic [BOW-1:0]    rd_off, b_off;
    logic [BOW:0]      rd_len;

    logic [NUM_BANKS-1:0] a_lane, b_lane, b_lane_we, a_bank_en, a_bank_we;
    logic [RAW-1:0]       a_bank_row [NUM_BANKS];
    logic [RAW-1:0]       b_bank_row [NUM_BANKS];
    logic [D_WID-1:0]     a_bank_wd  [NUM_BANKS];
    logic [D_WID-1:0]     b_bank_wd  [NUM_BANKS];
    logic [D_WID-1:0]     bank_a_q   [NUM_BANKS];
    logic [D_WID-1:0]     bank_b_q   [NUM_BANKS];
    logic [AW-1:0]        a_q_flat, b_q_flat;
    logic                 conflict, issue;

    // Per-bank lane decode for both ports plus the shared-row conflict test.
    always_comb begin
        logic [BOW-1:0]       ka, kb;
        bank_loc_t            la, lb;
        logic [SYS_LANES-1:0] lane_bit;
        a_lane    = '0;
        b_lane    = '0;
        b_lane_we = '0;
        conflict  = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            ka            = BOW'(b) - cur_addr[BOW-1:0];
            la            = bank_map(cur_addr, 32'(ka), BOW, RAW);
            a_lane[b]     = (la.bank == 32'(b)) && ({1'b0, ka} < cur_len);
            a_bank_row[b] = la.row[RAW-1:0];
            a_bank_wd[b]  = D_WID'(a_wr_data >> (32'(ka) * D_WID));

            kb            = BOW'(b) - b_addr[BOW-1:0];
            lb            = bank_map(b_addr, 32'(kb), BOW, RAW);
            lane_bit      = SYS_LANES'(1) << kb;
            b_lane[b]     = b_en && (lb.bank == 32'(b)) && (32'(kb) < SYS_LANES);
            b_lane_we[b]  = b_lane[b] && b_wr && (|(b_mask & lane_bit));
            b_bank_row[b] = lb.row[RAW-1:0];
            b_bank_wd[b]  = D_WID'(b_wr_data >> (32'(kb) * D_WID));

            if (state_q == BURST && a_lane[b] && b_lane[b] && la.row == lb.row
                && (cur_wr || b_lane_we[b]))
                conflict = 1'b1;
        end
    end

    assign issue       = (state_q == BURST) && !conflict;
    assign a_bank_en   = issue ? a_lane : '0;
    assign a_bank_we   = (issue && cur_wr) ? a_lane : '0;
    assign a_beat_ack  = issue;
    assign a_req_ready = (state_q == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (a_req_valid) state_d = BURST;
            BURST:   if (issue && cnt == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr     <= '0;
            cur_stride   <= '0;
            cur_len      <= '0;
            cur_wr       <= 1'b0;
            cnt          <= '0;
            rd_valid     <= 1'b0;
            rd_last      <= 1'b0;
            rd_off       <= '0;
            rd_len       <= '0;
            b_rd_valid_q <= 1'b0;
            b_off        <= '0;
        end else begin
            if (state_q == IDLE && a_req_valid) begin
                cur_addr   <= a_req_addr;
                cur_stride <= a_req_stride;
                cur_len    <= a_req_len;
                cur_wr     <= a_req_wr;
                cnt        <= a_req_beats;
            end else if (issue) begin
                cur_addr <= cur_addr + cur_stride;
                cnt      <= cnt - 1'b1;
            end
            rd_valid <= issue && !cur_wr;
            if (issue) begin
                rd_last <= (cnt == '0);
                rd_off  <= cur_addr[BOW-1:0];
                rd_len  <= cur_len;
            end
            b_rd_valid_q <= b_en && !b_wr;
            if (b_en) b_off <= b_addr[BOW-1:0];
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        bank_sram #(.D_WID(D_WID), .DEPTH(BANK_DEPTH)) u_bank (
            .clk    (clk),
            .a_en   (a_bank_en[g]),
            .a_we   (a_bank_we[g]),
            .a_addr (a_bank_row[g]),
            .a_wdata(a_bank_wd[g]),
            .a_rdata(bank_a_q[g]),
            .b_en   (b_lane[g]),
            .b_we   (b_lane_we[g]),
            .b_addr (b_bank_row[g]),
            .b_wdata(b_bank_wd[g]),
            .b_rdata(bank_b_q[g])
        );
        assign a_q_flat[g*D_WID +: D_WID] = bank_a_q[g];
        assign b_q_flat[g*D_WID +: D_WID] = bank_b_q[g];
    end

    // Rotate bank order back into lane order using the offsets registered at issue.
    always_comb begin
        logic [AW-1:0] rot_a;
        rot_a     = AW'({a_q_flat, a_q_flat} >> (32'(rd_off) * D_WID));
        a_rd_data = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (rd_valid && (BOW + 1)'(k) < rd_len)
                a_rd_data[k*D_WID +: D_WID] = rot_a[k*D_WID +: D_WID];
        end
        b_rd_data = b_rd_valid_q ? BW'({b_q_flat, b_q_flat} >> (32'(b_off) * D_WID)) : '0;
    end

    assign a_rd_valid = rd_valid;
    assign a_rd_last  = rd_valid && rd_last;
    assign b_rd_valid = b_rd_valid_q;

endmodule

// File: tb/tb_banked_scratchpad.sv
// Directed bench for banked_scratchpad: expected read beats queue up at issue
// time and a negedge monitor pops them as the DUT presents data.
module tb_banked_scratchpad;

    logic         clk = 1'b0;
    logic         rst;
    logic         a_req_valid, a_req_ready, a_req_wr;
    logic [31:0]  a_req_addr, a_req_stride;
    logic [4:0]   a_req_len;
    logic [7:0]   a_req_beats;
    logic [127:0] a_wr_data, a_rd_data;
    logic         a_beat_ack, a_rd_valid, a_rd_last;
    logic         b_en, b_wr;
    logic [3:0]   b_mask;
    logic [31:0]  b_addr, b_wr_data, b_rd_data;
    logic         b_rd_valid;

    int checks = 0;
    int errors = 0;
    logic [128:0] exp_a_q[$];
    logic [31:0]  exp_b_q[$];

    always #5 clk = ~clk;

    banked_scratchpad dut (
        .clk(clk), .rst(rst),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_wr(a_req_wr),
        .a_req_addr(a_req_addr), .a_req_len(a_req_len), .a_req_beats(a_req_beats),
        .a_req_stride(a_req_stride), .a_wr_data(a_wr_data), .a_beat_ack(a_beat_ack),
        .a_rd_valid(a_rd_valid), .a_rd_last(a_rd_last), .a_rd_data(a_rd_data),
        .b_en(b_en), .b_wr(b_wr), .b_mask(b_mask), .b_addr(b_addr),
        .b_wr_data(b_wr_data), .b_rd_data(b_rd_data), .b_rd_valid(b_rd_valid)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (a_rd_valid) begin
                if (exp_a_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_rd_unexpected: got %h expected none", a_rd_data);
                end else check("a_rd_beat", {a_rd_last, a_rd_data}, exp_a_q.pop_front());
            end
            if (b_rd_valid) begin
                if (exp_b_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_rd_unexpected: got %h expected none", b_rd_data);
                end else check("b_rd_word", b_rd_data, exp_b_q.pop_front());
            end
        end
    end

    task automatic b_op(input logic wr, input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] data);
        b_en = 1'b1; b_wr = wr; b_addr = addr; b_mask = mask; b_wr_data = data;
        @(posedge clk); #1;
        b_en = 1'b0; b_wr = 1'b0; b_mask = '0;
    endtask

    // One burst; optional B access driven in the first BURST cycle.
    task automatic do_burst(input logic wr, input logic [31:0] addr, input logic [4:0] len,
                            input logic [7:0] beats, input logic [31:0] stride,
                            input logic [127:0] data, input logic bf_en, input logic bf_wr,
                            input logic [31:0] bf_addr, input logic [3:0] bf_mask,
                            input logic [31:0] bf_data,
                            output int acks, output int cycles, output logic first_ack);
        a_req_valid = 1'b1; a_req_wr = wr; a_req_addr = addr; a_req_len = len;
        a_req_beats = beats; a_req_stride = stride; a_wr_data = data;
        @(negedge clk);
        check("req_ready_idle", a_req_ready, 1);
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        if (bf_en) begin
            b_en = 1'b1; b_wr = bf_wr; b_addr = bf_addr; b_mask = bf_mask; b_wr_data = bf_data;
        end
        acks = 0; cycles = 0; first_ack = 1'b0;
        while (acks < int'(beats) + 1 && cycles < 64) begin
            @(negedge clk);
            if (cycles == 0) first_ack = a_beat_ack;
            if (a_beat_ack) acks++;
            cycles++;
            @(posedge clk); #1;
            b_en = 1'b0; b_wr = 1'b0; b_mask = '0;
        end
    endtask

    initial begin
        int acks, cycles;
        logic first_ack;
        rst = 1'b1;
        a_req_valid = 0; a_req_wr = 0; a_req_addr = 0; a_req_len = 0; a_req_beats = 0;
        a_req_stride = 0; a_wr_data = 0;
        b_en = 0; b_wr = 0; b_mask = 0; b_addr = 0; b_wr_data = 0;

        repeat (2) @(negedge clk);
        check("rst_req_ready", a_req_ready, 1);
        check("rst_beat_ack", a_beat_ack, 0);
        check("rst_rd_valid", a_rd_valid, 0);
        check("rst_rd_last", a_rd_last, 0);
        check("rst_rd_data", a_rd_data, 0);
        check("rst_b_rd_valid", b_rd_valid, 0);
        check("rst_b_rd_data", b_rd_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Aligned write then read
        do_burst(1, 32'h00, 16, 0, 0, 128'h0F0E0D0C0B0A09080706050403020100, 0, 0, 0, 0, 0,
                 acks, cycles, first_ack);
        check("aligned_wr_acks", acks, 1);
        check("aligned_wr_cycles", cycles, 1);
        exp_a_q.push_back({1'b1, 128'h0F0E0D0C0B0A09080706050403020100});
        do_burst(0, 32'h00, 16, 0, 0, 0, 0, 0, 0, 0, 0, acks, cycles, first_ack);
        check("aligned_rd_acks", acks, 1);

        // Unaligned wrap via port B, read back on both ports
        b_op(1, 32'h0E, 4'hF, 32'hAABBCCDD);
        exp_b_q.push_back(32'hAABBCCDD);
        b_op(0, 32'h0E, 4'h0, 0);
        exp_a_q.push_back({1'b1, 96'h0, 32'hAABBCCDD});
        do_burst(0, 32'h0E, 4, 0, 0, 0, 0, 0, 0, 0, 0, acks, cycles, first_ack);
        check("wrap_rd_acks", acks, 1);

        // Strided write then strided read
        do_burst(1, 32'h20, 16, 2, 32'h20, 128'h4F4E4D4C4B4A49484746454443424140, 0, 0, 0, 0, 0,
                 acks, cycles, first_ack);
        check("stride_wr_acks", acks, 3);
        check("stride_wr_cycles", cycles, 3);
        exp_a_q.push_back({1'b0, 88'h0, 40'h0706050403});
        exp_a_q.push_back({1'b0, 88'h0, 40'h4746454443});
        exp_a_q.push_back({1'b0, 88'h0, 40'h4746454443});
        exp_a_q.push_back({1'b1, 88'h0, 40'h4746454443});
        do_burst(0, 32'h03, 5, 3, 32'h20, 0, 0, 0, 0, 0, 0, acks, cycles, first_ack);
        check("stride_rd_acks", acks, 4);
        check("stride_rd_cycles", cycles, 4);

        // Masked B write, then B read
        b_op(1, 32'h01, 4'b0101, 32'h5A6B7C8D);
        exp_b_q.push_back(32'h6B028D00);
        b_op(0, 32'h00, 4'h0, 0);

        // Zero-length read gives an all-zero beat
        exp_a_q.push_back({1'b1, 128'h0});
        do_burst(0, 32'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, acks, cycles, first_ack);
        check("len0_rd_acks", acks, 1);

        // Conflict stall: B write to a shared row wins, A issues next cycle
        do_burst(1, 32'h10, 4, 0, 0, 128'h44332211, 1, 1, 32'h12, 4'h1, 32'h99,
                 acks, cycles, first_ack);
        check("conflict_first_ack", first_ack, 0);
        check("conflict_acks", acks, 1);
        check("conflict_cycles", cycles, 2);

        // Read/read same row: no stall, A's data overwrote B's byte
        exp_a_q.push_back({1'b1, 96'h0, 32'h44332211});
        exp_b_q.push_back(32'h44332211);
        do_burst(0, 32'h10, 4, 0, 0, 0, 1, 0, 32'h10, 4'h0, 0, acks, cycles, first_ack);
        check("rdrd_first_ack", first_ack, 1);
        check("rdrd_cycles", cycles, 1);

        // Reset during beat 2 of an 8-beat write
        a_req_valid = 1; a_req_wr = 1; a_req_addr = 32'h80; a_req_len = 16; a_req_beats = 7;
        a_req_stride = 32'h10; a_wr_data = 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0;
        @(posedge clk); #1;
        a_req_valid = 0;
        @(negedge clk);
        check("midrst_beat1_ack", a_beat_ack, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_req_ready", a_req_ready, 1);
        check("midrst_beat_ack", a_beat_ack, 0);
        check("midrst_rd_valid", a_rd_valid, 0);
        check("midrst_rd_data", a_rd_data, 0);
        check("midrst_b_rd_valid", b_rd_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("postrst_req_ready", a_req_ready, 1);
        @(posedge clk); #1;
        exp_a_q.push_back({1'b1, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0});
        do_burst(0, 32'h80, 16, 0, 0, 0, 0, 0, 0, 0, 0, acks, cycles, first_ack);
        check("postrst_rd_acks", acks, 1);

        repeat (4) @(posedge clk);
        #1;
        check("a_queue_drained", exp_a_q.size(), 0);
        check("b_queue_drained", exp_b_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
